// File: rtl/smem_conflict_splitter.sv
// smem_conflict_splitter: splits a full-warp shared-memory request into bank-conflict-free passes.
// Loads broadcast-merge same-word lanes. Stores issue one lane per bank per pass, in ascending lane order.
// Optional feature macro: SMEM_SPLIT_STATS_EN adds request and extra-pass statistic counters.
module smem_conflict_splitter #(
   parameter int unsigned THREADS_PER_WARP = 32,
   parameter int unsigned NUM_BANKS        = 32,
   parameter int unsigned SHARED_MEM_SIZE  = 16384
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [31:0]                 in_address     [THREADS_PER_WARP-1:0],
   input  logic [31:0]                 in_write_data  [THREADS_PER_WARP-1:0],
   input  logic [3:0]                  in_byte_enable [THREADS_PER_WARP-1:0],
   input  logic [THREADS_PER_WARP-1:0] in_thread_mask,
   input  logic                        in_write_en,
   input  logic [5:0]                  in_warp_id,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [31:0]                 out_address     [THREADS_PER_WARP-1:0],
   output logic [31:0]                 out_write_data  [THREADS_PER_WARP-1:0],
   output logic [3:0]                  out_byte_enable [THREADS_PER_WARP-1:0],
   output logic [THREADS_PER_WARP-1:0] out_thread_mask,
   output logic                        out_write_en,
   output logic [5:0]                  out_warp_id,
   output logic [5:0]                  out_pass_idx,
   output logic                        out_last,
   output logic                        out_valid,
   input  logic                        out_ready
`ifdef SMEM_SPLIT_STATS_EN
   ,
   output logic [31:0]                 stat_req_count,
   output logic [31:0]                 stat_extra_pass_count
`endif
);

   localparam int unsigned T       = THREADS_PER_WARP;
   localparam int unsigned BANK_W  = $clog2(NUM_BANKS);
   localparam int unsigned WORD_HI = $clog2(SHARED_MEM_SIZE) - 1;
   localparam int unsigned WORD_W  = WORD_HI - 1;
   localparam int unsigned LANE_W  = (T > 1) ? $clog2(T) : 1;

   typedef enum logic [0:0] {IDLE, ISSUE} state_t;

   state_t            state_q, state_d;
   logic [T-1:0]      pending_q;
   logic [T-1:0]      sel;
   logic              accept;
   logic              fire;
   logic              issue;
   logic [BANK_W-1:0] lane_bank   [T];
   logic [WORD_W-1:0] lane_word   [T];
   logic [LANE_W-1:0] bank_leader [NUM_BANKS];

   assign issue     = (state_q == ISSUE);
   assign in_ready  = (state_q == IDLE);
   assign out_valid = issue;

   // Per-lane bank and in-range word index; upper address bits alias away
   always_comb begin
      for (int i = 0; i < int'(T); i++) begin
         lane_bank[i] = out_address[i][BANK_W+1:2];
         lane_word[i] = out_address[i][WORD_HI:2];
      end
   end

   // Leader per bank: lowest pending lane (descending scan so the lowest writes last)
   always_comb begin
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
         bank_leader[b] = '0;
      end
      for (int i = int'(T) - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            bank_leader[lane_bank[i]] = LANE_W'(i);
         end
      end
   end

   // Pass selection: leader only for stores, leader plus same-word lanes for loads
   always_comb begin
      sel = '0;
      for (int i = 0; i < int'(T); i++) begin
         if (pending_q[i]) begin
            if (out_write_en) begin
               sel[i] = (bank_leader[lane_bank[i]] == LANE_W'(i));
            end else begin
               sel[i] = (lane_word[bank_leader[lane_bank[i]]] == lane_word[i]);
            end
         end
      end
   end

   // Pass outputs are only meaningful while issuing
   always_comb begin
      out_thread_mask = '0;
      out_last        = 1'b0;
      if (issue) begin
         out_thread_mask = sel;
         out_last        = ((pending_q & ~sel) == '0);
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and handshake strobes
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      fire    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept = 1'b1;
               if (in_thread_mask != '0) begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (out_ready) begin
               fire = 1'b1;
               if (out_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request capture and per-pass retirement of served lanes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_address     <= '{default: '0};
         out_write_data  <= '{default: '0};
         out_byte_enable <= '{default: '0};
         out_write_en    <= 1'b0;
         out_warp_id     <= '0;
         out_pass_idx    <= '0;
         pending_q       <= '0;
      end else if (accept) begin
         out_address     <= in_address;
         out_write_data  <= in_write_data;
         out_byte_enable <= in_byte_enable;
         out_write_en    <= in_write_en;
         out_warp_id     <= in_warp_id;
         out_pass_idx    <= '0;
         pending_q       <= in_thread_mask;
      end else if (fire) begin
         pending_q       <= pending_q & ~sel;
         out_pass_idx    <= out_pass_idx + 6'd1;
      end
   end

`ifdef SMEM_SPLIT_STATS_EN
   // Statistics: non-empty requests accepted and passes beyond the first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_req_count        <= '0;
         stat_extra_pass_count <= '0;
      end else begin
         if (accept && (in_thread_mask != '0)) begin
            stat_req_count <= stat_req_count + 32'd1;
         end
         if (fire && (out_pass_idx != 6'd0)) begin
            stat_extra_pass_count <= stat_extra_pass_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_smem_conflict_splitter.sv
// tb_smem_conflict_splitter: directed and randomized checks of smem_conflict_splitter against a pass-list model.
// Honors SMEM_SPLIT_STATS_EN to connect and check the statistic counters.
module tb_smem_conflict_splitter;

   localparam int unsigned T    = 32;
   localparam int unsigned NB   = 32;
   localparam int unsigned SMEM = 16384;

   typedef struct {
      logic [31:0] mask;
      int          idx;
      bit          last;
   } pass_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_address      [T-1:0];
   logic [31:0] in_write_data   [T-1:0];
   logic [3:0]  in_byte_enable  [T-1:0];
   logic [31:0] in_thread_mask;
   logic        in_write_en;
   logic [5:0]  in_warp_id;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_address     [T-1:0];
   logic [31:0] out_write_data  [T-1:0];
   logic [3:0]  out_byte_enable [T-1:0];
   logic [31:0] out_thread_mask;
   logic        out_write_en;
   logic [5:0]  out_warp_id;
   logic [5:0]  out_pass_idx;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;
`ifdef SMEM_SPLIT_STATS_EN
   logic [31:0] stat_req_count;
   logic [31:0] stat_extra_pass_count;
`endif

   // Current request as the model sees it
   logic [31:0] req_addr [T-1:0];
   logic [31:0] req_data [T-1:0];
   logic [3:0]  req_be   [T-1:0];
   logic [31:0] req_mask;
   logic        req_we;
   logic [5:0]  req_warp;

   pass_t exp_q[$];
   int    mem[int];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    exp_reqs  = 0;
   int    exp_extra = 0;
   int    n_seen;

   smem_conflict_splitter dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_address      (in_address),
      .in_write_data   (in_write_data),
      .in_byte_enable  (in_byte_enable),
      .in_thread_mask  (in_thread_mask),
      .in_write_en     (in_write_en),
      .in_warp_id      (in_warp_id),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .out_address     (out_address),
      .out_write_data  (out_write_data),
      .out_byte_enable (out_byte_enable),
      .out_thread_mask (out_thread_mask),
      .out_write_en    (out_write_en),
      .out_warp_id     (out_warp_id),
      .out_pass_idx    (out_pass_idx),
      .out_last        (out_last),
      .out_valid       (out_valid),
      .out_ready       (out_ready)
`ifdef SMEM_SPLIT_STATS_EN
      ,
      .stat_req_count        (stat_req_count),
      .stat_extra_pass_count (stat_extra_pass_count)
`endif
   );

   always #5 clk = ~clk;

   // Bounded run time
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic int bank_of(input logic [31:0] a);
      return int'((a >> 2) % NB);
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a % SMEM) >> 2);
   endfunction

   // Model: each pass claims every bank for the first pending lane seen on it;
   // loads also take any later lane reading that claimed word.
   task automatic build_model();
      logic [31:0] pend;
      logic [31:0] sel;
      int          k;
      bit          taken [NB];
      int          bword [NB];
      int          b;
      int          w;
      pass_t       p;
      pend = req_mask;
      k    = 0;
      exp_q.delete();
      while (pend != 32'd0) begin
         sel = 32'd0;
         for (int j = 0; j < int'(NB); j++) begin
            taken[j] = 1'b0;
            bword[j] = 0;
         end
         for (int i = 0; i < int'(T); i++) begin
            if (pend[i]) begin
               b = bank_of(req_addr[i]);
               w = word_of(req_addr[i]);
               if (!taken[b]) begin
                  taken[b] = 1'b1;
                  bword[b] = w;
                  sel[i]   = 1'b1;
               end else if (!req_we && bword[b] == w) begin
                  sel[i] = 1'b1;
               end
            end
         end
         p.mask = sel;
         p.idx  = k;
         p.last = ((pend & ~sel) == 32'd0);
         exp_q.push_back(p);
         pend = pend & ~sel;
         k++;
      end
      if (req_mask != 32'd0) begin
         exp_reqs++;
         exp_extra += k - 1;
      end
   endtask

   // Present the request for one cycle (called and returning on a negedge)
   task automatic send_request();
      build_model();
      check_eq("in_ready_idle", in_ready, 1'b1);
      for (int i = 0; i < int'(T); i++) begin
         in_address[i]     = req_addr[i];
         in_write_data[i]  = req_data[i];
         in_byte_enable[i] = req_be[i];
      end
      in_thread_mask = req_mask;
      in_write_en    = req_we;
      in_warp_id     = req_warp;
      in_valid       = 1'b1;
      @(negedge clk);
      in_valid       = 1'b0;
   endtask

   // Consume expected passes with optional backpressure, checking every presented cycle
   task automatic run_request(input bit rand_bp, input int stall_at, input int stall_len,
                              input int max_pass, output int seen);
      pass_t e;
      int    stall;
      int    lane;
      bit    abort;
      abort = 1'b0;
      seen  = 0;
      while (exp_q.size() > 0 && !abort && seen < max_pass) begin
         e = exp_q[0];
         if (rand_bp) stall = $urandom_range(0, 2);
         else stall = (e.idx == stall_at) ? stall_len : 0;
         for (int s = 0; s <= stall && !abort; s++) begin
            check_eq("out_valid", out_valid, 1'b1);
            if (out_valid !== 1'b1) begin
               abort = 1'b1;
            end else begin
               lane = $urandom_range(0, T - 1);
               check_eq("pass_mask", out_thread_mask, e.mask);
               check_eq("pass_idx", out_pass_idx, e.idx);
               check_eq("pass_last", out_last, e.last);
               check_eq("in_ready_busy", in_ready, 1'b0);
               check_eq("out_addr", out_address[lane], req_addr[lane]);
               check_eq("out_wdata", out_write_data[lane], req_data[lane]);
               check_eq("out_be", out_byte_enable[lane], req_be[lane]);
               check_eq("out_we", out_write_en, req_we);
               check_eq("out_warp", out_warp_id, req_warp);
               out_ready = (s == stall);
               if (out_ready && out_write_en) begin
                  for (int i = 0; i < int'(T); i++) begin
                     if (out_thread_mask[i] && out_byte_enable[i] == 4'hF) begin
                        mem[word_of(out_address[i])] = int'(out_write_data[i]);
                     end
                  end
               end
               @(negedge clk);
            end
         end
         out_ready = 1'b0;
         if (!abort) begin
            void'(exp_q.pop_front());
            seen++;
         end
      end
      if (abort) exp_q.delete();
      if (!abort && exp_q.size() == 0) begin
         check_eq("idle_out_valid", out_valid, 1'b0);
         check_eq("idle_in_ready", in_ready, 1'b1);
      end
   endtask

   task automatic check_stats();
`ifdef SMEM_SPLIT_STATS_EN
      check_eq("stat_req", stat_req_count, 32'(exp_reqs));
      check_eq("stat_extra", stat_extra_pass_count, 32'(exp_extra));
`endif
   endtask

   task automatic set_uniform(input logic we, input logic [31:0] base, input logic [31:0] stride);
      for (int i = 0; i < int'(T); i++) begin
         req_addr[i] = base + stride * 32'(i);
         req_data[i] = 32'(i);
         req_be[i]   = 4'hF;
      end
      req_mask = 32'hFFFF_FFFF;
      req_we   = we;
      req_warp = 6'($urandom_range(0, 63));
   endtask

   task automatic gen_random();
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < int'(T); i++) begin
         case (mode)
            0: req_addr[i] = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 47)) << 2);
            1: req_addr[i] = (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 3)) << 7);
            default: req_addr[i] = $urandom;
         endcase
         req_data[i] = $urandom;
         req_be[i]   = 4'($urandom_range(0, 15));
      end
      req_mask = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      req_we   = 1'($urandom_range(0, 1));
      req_warp = 6'($urandom_range(0, 63));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < int'(T); i++) begin
         in_address[i]     = 32'd0;
         in_write_data[i]  = 32'd0;
         in_byte_enable[i] = 4'd0;
      end
      in_thread_mask = 32'd0;
      in_write_en    = 1'b0;
      in_warp_id     = 6'd0;
      repeat (2) @(negedge clk);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_in_ready", in_ready, 1'b1);
      check_eq("rst_mask", out_thread_mask, 32'd0);
      check_eq("rst_last", out_last, 1'b0);
      check_eq("rst_pass_idx", out_pass_idx, 6'd0);
      check_stats();
      rst_n = 1'b1;
      @(negedge clk);

      // Unit-stride load: single pass
      set_uniform(1'b0, 32'd0, 32'd4);
      send_request();
      run_request(1'b0, -1, 0, 99, n_seen);
      check_eq("c1_passes", n_seen, 1);
      check_stats();

      // All lanes on bank 0, distinct words: one pass per lane
      set_uniform(1'b0, 32'd0, 32'd128);
      send_request();
      run_request(1'b0, -1, 0, 99, n_seen);
      check_eq("c2_passes", n_seen, 32);
      check_stats();

      // Same-word load: broadcast in one pass
      set_uniform(1'b0, 32'h40, 32'd0);
      send_request();
      run_request(1'b0, -1, 0, 99, n_seen);
      check_eq("c3_passes", n_seen, 1);

      // Same-word store: serialized, last lane wins
      mem.delete();
      set_uniform(1'b1, 32'h40, 32'd0);
      send_request();
      run_request(1'b0, -1, 0, 99, n_seen);
      check_eq("c4_passes", n_seen, 32);
      check_eq("c4_read", mem.exists(16) ? mem[16] : -1, 31);
      check_stats();

      // Bank-0 conflict with a 5-cycle stall at pass 3
      set_uniform(1'b0, 32'd0, 32'd128);
      send_request();
      run_request(1'b0, 3, 5, 99, n_seen);
      check_eq("c5_passes", n_seen, 32);
      check_stats();

      // Randomized requests with random backpressure
      for (int r = 0; r < 40; r++) begin
         gen_random();
         send_request();
         run_request(1'b1, -1, 0, 99, n_seen);
         check_stats();
      end

      // Empty-mask request is dropped
      gen_random();
      req_mask = 32'd0;
      send_request();
      run_request(1'b0, -1, 0, 99, n_seen);
      check_eq("c6_empty_passes", n_seen, 0);
      @(negedge clk);
      check_eq("c6_empty_valid", out_valid, 1'b0);
      check_stats();

      // Reset mid-request
      set_uniform(1'b0, 32'd0, 32'd128);
      send_request();
      run_request(1'b0, -1, 0, 5, n_seen);
      exp_q.delete();
      rst_n = 1'b0;
      #1;
      exp_reqs  = 0;
      exp_extra = 0;
      check_eq("mid_rst_valid", out_valid, 1'b0);
      check_eq("mid_rst_in_ready", in_ready, 1'b1);
      check_eq("mid_rst_mask", out_thread_mask, 32'd0);
      check_eq("mid_rst_last", out_last, 1'b0);
      check_eq("mid_rst_idx", out_pass_idx, 6'd0);
      check_eq("mid_rst_warp", out_warp_id, 6'd0);
      check_eq("mid_rst_we", out_write_en, 1'b0);
      check_eq("mid_rst_addr", out_address[7], 32'd0);
      check_stats();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      set_uniform(1'b0, 32'd0, 32'd4);
      send_request();
      run_request(1'b0, -1, 0, 99, n_seen);
      check_eq("post_rst_passes", n_seen, 1);
      check_stats();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
